// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment scanner for the alarm clock display.
// Optional macro CLOCK_DISPLAY_LZB_EN blanks a zero hour-tens digit.
module clock_display_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2,
  parameter int BLINK_TICKS = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] hour_msb,
  input  logic [3:0] hour_lsb,
  input  logic [3:0] min_msb,
  input  logic [3:0] min_lsb,
  input  logic [3:0] sec_msb,
  input  logic [3:0] sec_lsb,
  input  logic       alarm,
  output logic [5:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW =
    (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_idx;
  logic [BW-1:0]      r_bcnt;
  logic               r_phase;
  logic [5:0][3:0]    r_lat;

  logic               w_tick;
  logic               w_guard;
  logic               w_blank;
  logic               w_lzb;
  logic [3:0]         w_dig;
  logic [6:0]         w_seg;
  logic [5:0]         w_an_nxt;
  logic [6:0]         w_seg_nxt;
  logic               w_dp_nxt;

  assign w_tick  = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_guard = (r_cnt < CW'(GUARD));
  // Gate with the live alarm so dropping it restores the display at once
  assign w_blank = r_phase & alarm;
  assign w_dig   = r_lat[r_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Whole-frame snapshot keeps a frame from mixing two different times
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lat <= '0;
    end else if (w_tick && r_idx == 3'd5) begin
      r_lat[0] <= sec_lsb;
      r_lat[1] <= sec_msb;
      r_lat[2] <= min_lsb;
      r_lat[3] <= min_msb;
      r_lat[4] <= hour_lsb;
      r_lat[5] <= {2'b00, hour_msb};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (!alarm) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_tick) begin
      if (r_bcnt == BW'(BLINK_TICKS - 1)) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_seg = 7'b0111111;
    unique case (w_dig)
      4'd0: w_seg = 7'b1000000;
      4'd1: w_seg = 7'b1111001;
      4'd2: w_seg = 7'b0100100;
      4'd3: w_seg = 7'b0110000;
      4'd4: w_seg = 7'b0011001;
      4'd5: w_seg = 7'b0010010;
      4'd6: w_seg = 7'b0000010;
      4'd7: w_seg = 7'b1111000;
      4'd8: w_seg = 7'b0000000;
      4'd9: w_seg = 7'b0010000;
      default: w_seg = 7'b0111111;
    endcase
  end

  always_comb begin
    w_lzb = 1'b0;
`ifdef CLOCK_DISPLAY_LZB_EN
    w_lzb = (r_idx == 3'd5) && (r_lat[5] == 4'd0);
`endif
  end

  always_comb begin
    w_an_nxt  = 6'b111111;
    w_seg_nxt = w_seg;
    w_dp_nxt  = ~((r_idx == 3'd2) || (r_idx == 3'd4));
    if (!(w_guard || w_blank))
      w_an_nxt = ~(6'd1 << r_idx);
    if (w_lzb) begin
      w_seg_nxt = 7'b1111111;
      w_dp_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_n  <= 6'b111111;
      seg_n <= 7'b1111111;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= w_an_nxt;
      seg_n <= w_seg_nxt;
      dp_n  <= w_dp_nxt;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: random and directed stimulus
// against a cycle-count based reference of the scan behaviour.
module tb_clock_display_scan;

  localparam int DIV = 4;
  localparam int GRD = 1;
  localparam int BT  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] hour_msb = '0;
  logic [3:0] hour_lsb = '0;
  logic [3:0] min_msb = '0;
  logic [3:0] min_lsb = '0;
  logic [3:0] sec_msb = '0;
  logic [3:0] sec_lsb = '0;
  logic       alarm = 1'b0;
  logic [5:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  int n_cmp = 0;
  int n_bad = 0;

  clock_display_scan #(
    .REFRESH_DIV(DIV),
    .GUARD(GRD),
    .BLINK_TICKS(BT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hour_msb(hour_msb),
    .hour_lsb(hour_lsb),
    .min_msb(min_msb),
    .min_lsb(min_lsb),
    .sec_msb(sec_msb),
    .sec_lsb(sec_lsb),
    .alarm(alarm),
    .an_n(an_n),
    .seg_n(seg_n),
    .dp_n(dp_n)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000
  };

  // Reference: time since reset, a frame snapshot, slot ticks under alarm
  int         m_t;
  int         m_bt;
  logic [3:0] m_lat [6];
  int         mc;
  int         mi;
  logic       mph;
  logic [3:0] md;
  logic [5:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  int         e_idx;
  int         e_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t = 0;
      m_bt = 0;
      for (int k = 0; k < 6; k++) m_lat[k] = 4'd0;
      e_an = 6'h3f;
      e_seg = 7'h7f;
      e_dp = 1'b1;
      e_idx = 0;
      e_cnt = 0;
    end else begin
      mc = m_t % DIV;
      mi = (m_t / DIV) % 6;
      mph = (((m_bt / BT) % 2) == 1) && alarm;
      md = m_lat[mi];
      e_seg = (md > 4'd9) ? 7'b0111111 : tbl[md];
      e_dp = !(mi == 2 || mi == 4);
`ifdef CLOCK_DISPLAY_LZB_EN
      if (mi == 5 && md == 4'd0) begin
        e_seg = 7'h7f;
        e_dp = 1'b1;
      end
`endif
      e_an = (mc < GRD || mph) ? 6'h3f : ~(6'd1 << mi);
      e_idx = mi;
      e_cnt = mc;
      if (mc == DIV - 1 && mi == 5) begin
        m_lat[0] = sec_lsb;
        m_lat[1] = sec_msb;
        m_lat[2] = min_lsb;
        m_lat[3] = min_msb;
        m_lat[4] = hour_lsb;
        m_lat[5] = {2'b00, hour_msb};
      end
      if (!alarm) m_bt = 0;
      else if (mc == DIV - 1) m_bt++;
      m_t++;
    end
  end

  task automatic set_time(input int hh, input int mm,
                          input int ss);
    hour_msb = 2'(hh / 10);
    hour_lsb = 4'(hh % 10);
    min_msb  = 4'(mm / 10);
    min_lsb  = 4'(mm % 10);
    sec_msb  = 4'(ss / 10);
    sec_lsb  = 4'(ss % 10);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      n_cmp++;
      if (an_n !== e_an || seg_n !== e_seg || dp_n !== e_dp) begin
        n_bad++;
        $display("FAIL prereset c=%0d an=%b seg=%b dp=%b want %b %b %b",
                 c, an_n, seg_n, dp_n, e_an, e_seg, e_dp);
      end
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (an_n !== 6'h3f || seg_n !== 7'h7f || dp_n !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset an=%b seg=%b dp=%b want 111111 1111111 1",
               an_n, seg_n, dp_n);
    end
    set_time(12, 34, 56);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (an_n !== 6'h3f || seg_n !== 7'b1000000) begin
      n_bad++;
      $display("FAIL first_slot an=%b seg=%b want 111111 1000000",
               an_n, seg_n);
    end
    for (int c = 1; c < 24; c++) begin
      @(negedge clk);
      n_cmp++;
      if (an_n !== e_an || seg_n !== e_seg || dp_n !== e_dp) begin
        n_bad++;
        $display("FAIL frame0 c=%0d an=%b seg=%b dp=%b want %b %b %b",
                 c, an_n, seg_n, dp_n, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_digits();
    int act0;
    act0 = 0;
    set_time(12, 34, 56);
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      n_cmp++;
      if (an_n !== e_an || seg_n !== e_seg || dp_n !== e_dp) begin
        n_bad++;
        $display("FAIL digits c=%0d an=%b seg=%b dp=%b want %b %b %b",
                 c, an_n, seg_n, dp_n, e_an, e_seg, e_dp);
      end
      if (c >= 48) begin
        if (an_n === 6'b111110) act0++;
        if (e_cnt < GRD) begin
          n_cmp++;
          if (an_n !== 6'h3f) begin
            n_bad++;
            $display("FAIL guard an=%b want 111111", an_n);
          end
        end else if (e_idx == 0) begin
          n_cmp++;
          if (seg_n !== 7'b0000010) begin
            n_bad++;
            $display("FAIL dig0 seg=%b want 0000010", seg_n);
          end
        end else if (e_idx == 2) begin
          n_cmp++;
          if (seg_n !== 7'b0011001 || dp_n !== 1'b0) begin
            n_bad++;
            $display("FAIL dig2 seg=%b dp=%b want 0011001 0",
                     seg_n, dp_n);
          end
        end else if (e_idx == 5) begin
          n_cmp++;
          if (seg_n !== 7'b1111001) begin
            n_bad++;
            $display("FAIL dig5 seg=%b want 1111001", seg_n);
          end
        end
      end
    end
    n_cmp++;
    if (act0 != DIV - GRD) begin
      n_bad++;
      $display("FAIL frame_period dig0_cycles=%0d want %0d",
               act0, DIV - GRD);
    end
  endtask

  task automatic test_midframe();
    int bound;
    int frame;
    bound = 0;
    while (((m_t / DIV) % 6) != 2 && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    n_cmp++;
    if (bound >= 50) begin
      n_bad++;
      $display("FAIL midframe_wait idx never 2");
    end
    set_time(23, 59, 59);
    frame = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (e_idx == 0 && e_cnt == 0) frame++;
      n_cmp++;
      if (an_n !== e_an || seg_n !== e_seg || dp_n !== e_dp) begin
        n_bad++;
        $display("FAIL midframe c=%0d an=%b seg=%b want %b %b",
                 c, an_n, seg_n, e_an, e_seg);
      end
      if (e_idx == 5 && frame == 0) begin
        n_cmp++;
        if (seg_n !== 7'b1111001) begin
          n_bad++;
          $display("FAIL old_frame seg=%b want 1111001", seg_n);
        end
      end
      if (e_idx == 5 && frame == 1) begin
        n_cmp++;
        if (seg_n !== 7'b0100100) begin
          n_bad++;
          $display("FAIL new_frame seg=%b want 0100100", seg_n);
        end
      end
    end
  endtask

  task automatic test_dash();
    sec_lsb = 4'hB;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      n_cmp++;
      if (an_n !== e_an || seg_n !== e_seg || dp_n !== e_dp) begin
        n_bad++;
        $display("FAIL dash c=%0d an=%b seg=%b want %b %b",
                 c, an_n, seg_n, e_an, e_seg);
      end
      if (c >= 24 && e_idx == 0) begin
        n_cmp++;
        if (seg_n !== 7'b0111111) begin
          n_bad++;
          $display("FAIL dash_dig0 seg=%b want 0111111", seg_n);
        end
      end
    end
  endtask

  task automatic test_blink();
    int bound;
    alarm = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_cmp++;
      if (an_n !== e_an || seg_n !== e_seg) begin
        n_bad++;
        $display("FAIL blink c=%0d an=%b seg=%b want %b %b",
                 c, an_n, seg_n, e_an, e_seg);
      end
    end
    bound = 0;
    while (!(e_an == 6'h3f && e_cnt >= GRD) && bound < 60) begin
      @(negedge clk);
      bound++;
    end
    n_cmp++;
    if (bound >= 60 || an_n !== 6'h3f) begin
      n_bad++;
      $display("FAIL blank_phase an=%b want 111111 bound=%0d",
               an_n, bound);
    end
    alarm = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (an_n !== ((e_cnt < GRD) ? 6'h3f : ~(6'd1 << e_idx))) begin
      n_bad++;
      $display("FAIL alarm_drop an=%b cnt=%0d idx=%0d",
               an_n, e_cnt, e_idx);
    end
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      n_cmp++;
      if (an_n !== e_an) begin
        n_bad++;
        $display("FAIL post_alarm an=%b want %b", an_n, e_an);
      end
    end
  endtask

  task automatic test_lzb(input int hh, input logic [6:0] want);
    set_time(hh, 0, 0);
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      n_cmp++;
      if (an_n !== e_an || seg_n !== e_seg || dp_n !== e_dp) begin
        n_bad++;
        $display("FAIL lzb c=%0d an=%b seg=%b want %b %b",
                 c, an_n, seg_n, e_an, e_seg);
      end
      if (c >= 24 && e_idx == 5) begin
        n_cmp++;
        if (seg_n !== want || dp_n !== 1'b1) begin
          n_bad++;
          $display("FAIL lzb_dig5 hh=%0d seg=%b want %b",
                   hh, seg_n, want);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_cmp++;
      if (an_n !== e_an || seg_n !== e_seg || dp_n !== e_dp) begin
        n_bad++;
        $display("FAIL random c=%0d an=%b seg=%b dp=%b want %b %b %b",
                 c, an_n, seg_n, dp_n, e_an, e_seg, e_dp);
      end
      if ($urandom_range(0, 9) == 0) begin
        hour_msb = 2'($urandom);
        hour_lsb = 4'($urandom);
        min_msb  = 4'($urandom);
        min_lsb  = 4'($urandom);
        sec_msb  = 4'($urandom);
        sec_lsb  = 4'($urandom);
      end
      if ($urandom_range(0, 39) == 0) alarm = ~alarm;
    end
    alarm = 1'b0;
  endtask

  initial begin
    test_reset();
    test_digits();
    test_midframe();
    test_dash();
    test_blink();
`ifdef CLOCK_DISPLAY_LZB_EN
    test_lzb(7, 7'b1111111);
`else
    test_lzb(7, 7'b1000000);
`endif
    test_lzb(17, 7'b1111001);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
